demux3_buf: RTL and testbench



---
 rtl/demux3_buf.sv | 99 +++++++++
 tb/tb_demux3_buf.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux3_buf.sv
// Buffered 1:3 demultiplexer: one producer stream routed by s into three
// per-channel FIFOs with valid/ready. Optional stall counter: DEMUX3_STALL_CNT_EN.
module demux3_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  output logic [15:0]      stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem    [3][DEPTH];
  logic [PW-1:0]    wr_ptr [3];
  logic [PW-1:0]    rd_ptr [3];
  logic [CW-1:0]    count  [3];
  logic [WIDTH-1:0] last   [3];
  logic [WIDTH-1:0] head   [3];
  logic [2:0]       sel_oh, full, valid, rdy, push, pop;

  always_comb begin
    sel_oh = s[1] ? 3'b100 : (s[0] ? 3'b010 : 3'b001);
    rdy    = {r2, r1, r0};
    for (int unsigned i = 0; i < 3; i++) begin
      full[i]  = (count[i] == CW'(DEPTH));
      valid[i] = (count[i] != '0);
      // An empty channel shows the word most recently popped, not stale storage.
      head[i]  = valid[i] ? mem[i][rd_ptr[i]] : last[i];
    end
    in_ready = ~|(sel_oh & full);
    push     = {3{in_valid & in_ready & ~reset}} & sel_oh;
    pop      = valid & rdy & {3{~reset}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        last[i]   <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= d;
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          last[i]   <= mem[i][rd_ptr[i]];
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign y0 = head[0];
  assign y1 = head[1];
  assign y2 = head[2];
  assign v0 = valid[0];
  assign v1 = valid[1];
  assign v2 = valid[2];

`ifdef DEMUX3_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_demux3_buf.sv
// Scoreboard bench for demux3_buf: stimulus queues expected words per channel,
// a negedge monitor checks valid/head data and retires words on handshakes.
module tb_demux3_buf;

`ifdef DEMUX3_STALL_CNT_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  d = '0;
  logic [1:0]  s = '0;
  logic [7:0]  y0, y1, y2;
  logic        v0, v1, v2;
  logic        r0 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] q [3][$];

  demux3_buf #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .s(s), .y0(y0), .y1(y1), .y2(y2), .v0(v0), .v1(v1), .v2(v2),
    .r0(r0), .r1(r1), .r2(r2), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs are stable from posedge+1 through the next posedge.
  always @(negedge clk) begin
    logic [2:0] vv, rr;
    logic [7:0] yy [3];
    if (!reset) begin
      vv = {v2, v1, v0};
      rr = {r2, r1, r0};
      yy[0] = y0; yy[1] = y1; yy[2] = y2;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("valid%0d", i), {31'd0, vv[i]}, {31'd0, q[i].size() != 0});
        if (vv[i] && q[i].size() != 0) begin
          chk($sformatf("head%0d", i), {24'd0, yy[i]}, {24'd0, q[i][0]});
          if (rr[i]) void'(q[i].pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                     input logic [2:0] r, input logic exp_rdy, input int ch);
    in_valid = iv; s = sel; d = data; {r2, r1, r0} = r;
    @(negedge clk);
    if (iv) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    #1;
    if (iv && exp_rdy) q[ch].push_back(data);
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    for (int i = 0; i < 3; i++) q[i].delete();
  endtask

  task automatic chk_idle_reset_state(input string tag);
    chk({tag, "_v0"}, {31'd0, v0}, 32'd0);
    chk({tag, "_v1"}, {31'd0, v1}, 32'd0);
    chk({tag, "_v2"}, {31'd0, v2}, 32'd0);
    chk({tag, "_y0"}, {24'd0, y0}, 32'd0);
    chk({tag, "_y1"}, {24'd0, y1}, 32'd0);
    chk({tag, "_y2"}, {24'd0, y2}, 32'd0);
    chk({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_idle_reset_state("reset");

    // Single push to channel 0, then pop; empty channel keeps last read word.
    cyc(1'b1, 2'b00, 8'hA5, 3'b000, 1'b1, 0);
    chk("t1_v0", {31'd0, v0}, 32'd1);
    chk("t1_y0", {24'd0, y0}, 32'hA5);
    chk("t1_v1", {31'd0, v1}, 32'd0);
    chk("t1_y2", {24'd0, y2}, 32'd0);
    cyc(1'b0, 2'b00, 8'h00, 3'b001, 1'b0, 0);
    chk("t1_v0_after_pop", {31'd0, v0}, 32'd0);
    chk("t1_y0_hold", {24'd0, y0}, 32'hA5);

    // Channel 1 fill to full, refused push, pop with refused push, retry.
    cyc(1'b1, 2'b01, 8'h11, 3'b000, 1'b1, 1);
    cyc(1'b1, 2'b01, 8'h22, 3'b000, 1'b1, 1);
    cyc(1'b1, 2'b01, 8'h33, 3'b000, 1'b0, 1);
    cyc(1'b1, 2'b01, 8'h33, 3'b010, 1'b0, 1);
    cyc(1'b1, 2'b01, 8'h33, 3'b010, 1'b1, 1);
    cyc(1'b0, 2'b01, 8'h00, 3'b010, 1'b0, 1);
    chk("t2_v1_drained", {31'd0, v1}, 32'd0);
    chk("t2_y1_hold", {24'd0, y1}, 32'h33);

    // s=10 and s=11 both select channel 2.
    cyc(1'b1, 2'b10, 8'h3C, 3'b000, 1'b1, 2);
    cyc(1'b1, 2'b11, 8'hC3, 3'b000, 1'b1, 2);
    chk("t3_v2", {31'd0, v2}, 32'd1);
    chk("t3_y2", {24'd0, y2}, 32'h3C);
    chk("t3_v0", {31'd0, v0}, 32'd0);
    chk("t3_v1", {31'd0, v1}, 32'd0);
    cyc(1'b1, 2'b11, 8'hEE, 3'b000, 1'b0, 2);
    cyc(1'b0, 2'b00, 8'h00, 3'b100, 1'b0, 0);
    cyc(1'b0, 2'b00, 8'h00, 3'b100, 1'b0, 0);

    // Full channel 0 does not block channel 2.
    cyc(1'b1, 2'b00, 8'h01, 3'b000, 1'b1, 0);
    cyc(1'b1, 2'b00, 8'h02, 3'b000, 1'b1, 0);
    cyc(1'b1, 2'b00, 8'h33, 3'b000, 1'b0, 0);
    cyc(1'b1, 2'b10, 8'h77, 3'b000, 1'b1, 2);
    chk("t4_v2", {31'd0, v2}, 32'd1);
    chk("t4_y2", {24'd0, y2}, 32'h77);
    chk("t4_y0", {24'd0, y0}, 32'h01);
    cyc(1'b0, 2'b00, 8'h00, 3'b101, 1'b0, 0);
    cyc(1'b0, 2'b00, 8'h00, 3'b101, 1'b0, 0);

    // Channel 1 at count 1: simultaneous push and pop keeps it at 1.
    cyc(1'b1, 2'b01, 8'h10, 3'b000, 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 2'b01, 8'h5A + 8'(k), 3'b010, 1'b1, 1);
      chk("t5_v1_steady", {31'd0, v1}, 32'd1);
    end
    cyc(1'b0, 2'b01, 8'h00, 3'b010, 1'b0, 1);
    chk("t5_v1_drained", {31'd0, v1}, 32'd0);
    chk("t5_y1_last", {24'd0, y1}, 32'h5D);

    // Stall counting into a full channel 0, from a freshly reset state.
    reset = 1'b1; clear_q();
    @(posedge clk); #1 reset = 1'b0;
    cyc(1'b1, 2'b00, 8'hAA, 3'b000, 1'b1, 0);
    cyc(1'b1, 2'b00, 8'hBB, 3'b000, 1'b1, 0);
    chk("t6_stall_before", {16'd0, stall_cnt}, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'b00, 8'hCC, 3'b000, 1'b0, 0);
    chk("t6_stall_cnt", {16'd0, stall_cnt}, 32'(5 * STALL_ON));
    cyc(1'b1, 2'b01, 8'h44, 3'b000, 1'b1, 1);

    // Reset mid-stream with push and pops pending.
    in_valid = 1'b1; s = 2'b01; d = 8'h55; {r2, r1, r0} = 3'b111;
    reset = 1'b1; clear_q();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; s = 2'b00; {r2, r1, r0} = 3'b000;
    chk_idle_reset_state("midreset");
    cyc(1'b0, 2'b00, 8'h00, 3'b000, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("scoreboard_empty%0d", i), 32'(q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
